mul_hilo_ctrl: RTL and testbench
================================

MUL_HILO_CTRL -- requirements
Module: mul_hilo_ctrl

Interface
REQ-001 Parameters SHALL be:
- MULTU, default 6'b011001, ALU op code that starts a multiply.
- MFHI, default 6'b010000, op code that reads HI.
- MFLO, default 6'b010010, op code that reads LO.
- OUT, default 6'b111111, multiplier unload code.
- NOP, default 6'b000000, idle code.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Signal  in  6  ALU op code from the decoder.
- dataA  in  32  multiplicand.
- dataB  in  32  multiplier.
- mul_signal  out  6  code driven to the shift-add multiplier's Signal input (registered).
- mul_dataA  out  32  latched multiplicand to the multiplier.
- mul_dataB  out  32  latched multiplier to the multiplier.
- mul_dataOut  in  64  product from the multiplier.
- rd_data  out  32  HI or LO read result.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse when HI/LO are updated.
- stall  out  1  MFHI/MFLO requested while busy.

Function
REQ-003 The FSM SHALL have states IDLE, RUN, UNLOAD, CAPTURE.
REQ-004 IDLE with Signal==MULTU at a clock edge SHALL latch dataA/dataB into mul_dataA/mul_dataB, clear the 5-bit counter, and enter RUN.
REQ-005 RUN SHALL drive mul_signal=MULTU for exactly 32 consecutive cycles; the counter increments each edge, and at count 31 the FSM enters UNLOAD.
REQ-006 UNLOAD SHALL drive mul_signal=OUT for exactly one cycle, then enter CAPTURE.
REQ-007 CAPTURE SHALL drive mul_signal=NOP. At the next edge it SHALL load HI<=mul_dataOut[63:32] and LO<=mul_dataOut[31:0], pulse done for one cycle, and return to IDLE.
REQ-008 mul_signal SHALL be NOP in IDLE, so every RUN entry presents a NOP->MULTU transition to the multiplier.
REQ-009 Latency SHALL be: done high in the 34th cycle after the accepting edge.
REQ-010 busy SHALL be 1 in RUN, UNLOAD and CAPTURE, and 0 in IDLE.
REQ-011 MULTU while busy SHALL be ignored; operands and counter remain unchanged.
REQ-012 rd_data SHALL be combinational: HI when Signal==MFHI, LO when Signal==MFLO, otherwise 32'b0.
REQ-013 stall SHALL be 1 when Signal is MFHI or MFLO and busy==1. rd_data then shows the pre-multiply HI/LO.
REQ-014 MULTU arriving in the same cycle as done SHALL be accepted, since the FSM is in IDLE after that edge.
REQ-015 The product SHALL be treated as unsigned 64-bit; no sign handling.

Reset
REQ-016 reset low SHALL asynchronously force: state IDLE, counter 0, mul_signal NOP, mul_dataA/mul_dataB 0, HI/LO 0, done 0.
REQ-017 Reset mid-operation SHALL abort the multiply with HI/LO cleared; the partial product is never captured.
REQ-018 After reset deassertion, the first MULTU SHALL be accepted at the first clock edge.

Structure
REQ-019 Op codes (MULTU, MFHI, MFLO, OUT, NOP) and the FSM state encoding SHALL live in the shared package alu_ops_pkg, reused by the decoder and the multiplier.
REQ-020 The HI/LO register pair SHALL be a sub-module hilo_reg: 64-bit write enable, asynchronous active-low clear, two 32-bit read ports.
REQ-021 Implementation SHALL be 120-400 lines of RTL.

Verification
REQ-022 Basic multiply: dataA=3, dataB=5, MULTU for one cycle, with a behavioural multiplier model. Required: HI=0, LO=15, done at cycle 34, mul_signal=MULTU for exactly 32 cycles then OUT for exactly 1 cycle.
REQ-023 Maximum operands: dataA=dataB=32'hFFFFFFFF. Required: HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-024 Read during busy: MFHI issued at RUN count 10 with HI=32'h12345678 from a prior multiply. Required: stall=1 and rd_data=32'h12345678; after done, MFLO gives stall=0.
REQ-025 Reset mid-run: reset low at RUN count 10. Required: immediately busy=0, mul_signal=NOP, HI=LO=0; no done pulse follows.
REQ-026 Back-to-back: second MULTU (7x9) issued at count 5, then again in the done cycle. Required: the first is ignored; the second is accepted, giving LO=63, HI=0.

Source files
------------

// File: rtl/alu_ops_pkg.sv
// alu_ops_pkg
//   Op codes shared by the decoder, the HI/LO controller and the shift-add
//   multiplier. Also holds the state encoding of the multiply controller FSM.
package alu_ops_pkg;

   localparam logic [5:0] OP_MULTU = 6'b011001;  // start multiply
   localparam logic [5:0] OP_MFHI  = 6'b010000;  // read HI
   localparam logic [5:0] OP_MFLO  = 6'b010010;  // read LO
   localparam logic [5:0] OP_OUT   = 6'b111111;  // multiplier unload
   localparam logic [5:0] OP_NOP   = 6'b000000;  // idle

   localparam int unsigned MUL_CNT_W = 5;
   localparam logic [MUL_CNT_W-1:0] MUL_CNT_LAST = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_UNLOAD  = 2'd2,
      ST_CAPTURE = 2'd3
   } mul_state_e;

endpackage : alu_ops_pkg

// File: rtl/hilo_reg.sv
// hilo_reg
//   HI/LO register pair written as one 64-bit value.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low clear of HI and LO
//   i_we     : write enable for the full 64-bit pair
//   i_wdata  : {HI, LO} write data
//   o_hi     : HI read port
//   o_lo     : LO read port
module hilo_reg (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_we,
   input  logic [63:0] i_wdata,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo
);

   logic [31:0] r_hi;
   logic [31:0] r_lo;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (i_we) begin
         r_hi <= i_wdata[63:32];
         r_lo <= i_wdata[31:0];
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule : hilo_reg

// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl
//   Sequences an external 32-cycle shift-add multiplier for MULTU and holds
//   the unsigned 64-bit product in HI/LO for MFHI/MFLO reads.
//   clk         : clock, all state on rising edge
//   reset       : asynchronous active-low reset
//   Signal      : ALU op code from the decoder
//   dataA/dataB : operands, latched when MULTU is accepted
//   mul_signal  : registered code to the multiplier (NOP/MULTU/OUT)
//   mul_dataA/B : latched operands to the multiplier
//   mul_dataOut : product from the multiplier
//   rd_data     : combinational HI/LO read result (0 for other codes)
//   busy        : multiply in progress
//   done        : one-cycle pulse when HI/LO are updated
//   stall       : MFHI/MFLO requested while busy
module mul_hilo_ctrl
   import alu_ops_pkg::*;
#(
   parameter logic [5:0] MULTU = OP_MULTU,
   parameter logic [5:0] MFHI  = OP_MFHI,
   parameter logic [5:0] MFLO  = OP_MFLO,
   parameter logic [5:0] OUT   = OP_OUT,
   parameter logic [5:0] NOP   = OP_NOP
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  Signal,
   input  logic [31:0] dataA,
   input  logic [31:0] dataB,
   output logic [5:0]  mul_signal,
   output logic [31:0] mul_dataA,
   output logic [31:0] mul_dataB,
   input  logic [63:0] mul_dataOut,
   output logic [31:0] rd_data,
   output logic        busy,
   output logic        done,
   output logic        stall
);

   mul_state_e               r_state;
   mul_state_e               w_state_nxt;
   logic [MUL_CNT_W-1:0]     r_cnt;
   logic [MUL_CNT_W-1:0]     w_cnt_nxt;
   logic [5:0]               r_mul_signal;
   logic [5:0]               w_sig_nxt;
   logic [31:0]              r_mul_dataA;
   logic [31:0]              r_mul_dataB;
   logic                     r_done;
   logic                     w_latch;
   logic                     w_capture;
   logic [31:0]              w_hi;
   logic [31:0]              w_lo;
   logic                     w_busy;
   logic                     w_is_rd;

   // mul_signal is registered, so the code for the next cycle is chosen here
   // together with the next state; IDLE always issues NOP so each RUN entry
   // shows the multiplier a NOP->MULTU edge.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sig_nxt   = NOP;
      w_latch     = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (Signal == MULTU) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
               w_sig_nxt   = MULTU;
               w_latch     = 1'b1;
            end
         end
         ST_RUN: begin
            w_cnt_nxt = r_cnt + 5'd1;
            if (r_cnt == MUL_CNT_LAST) begin
               w_state_nxt = ST_UNLOAD;
               w_sig_nxt   = OUT;
            end else begin
               w_sig_nxt   = MULTU;
            end
         end
         ST_UNLOAD: begin
            w_state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            w_capture   = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_mul_signal <= NOP;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_mul_signal <= w_sig_nxt;
         r_done       <= w_capture;
      end
   end

   // Operands only move on acceptance, so a MULTU while busy leaves them alone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mul_dataA <= '0;
         r_mul_dataB <= '0;
      end else if (w_latch) begin
         r_mul_dataA <= dataA;
         r_mul_dataB <= dataB;
      end
   end

   hilo_reg u_hilo (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_we    (w_capture),
      .i_wdata (mul_dataOut),
      .o_hi    (w_hi),
      .o_lo    (w_lo)
   );

   assign w_busy  = (r_state != ST_IDLE);
   assign w_is_rd = (Signal == MFHI) || (Signal == MFLO);

   always_comb begin
      rd_data = '0;
      if (Signal == MFHI) begin
         rd_data = w_hi;
      end else if (Signal == MFLO) begin
         rd_data = w_lo;
      end
   end

   assign mul_signal = r_mul_signal;
   assign mul_dataA  = r_mul_dataA;
   assign mul_dataB  = r_mul_dataB;
   assign busy       = w_busy;
   assign done       = r_done;
   assign stall      = w_is_rd && w_busy;

endmodule : mul_hilo_ctrl

// File: tb/tb_mul_hilo_ctrl.sv
module tb_mul_hilo_ctrl;

   localparam logic [5:0] C_MULTU = 6'b011001;
   localparam logic [5:0] C_MFHI  = 6'b010000;
   localparam logic [5:0] C_MFLO  = 6'b010010;
   localparam logic [5:0] C_OUT   = 6'b111111;
   localparam logic [5:0] C_NOP   = 6'b000000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  Signal = C_NOP;
   logic [31:0] dataA = '0;
   logic [31:0] dataB = '0;
   logic [5:0]  mul_signal;
   logic [31:0] mul_dataA;
   logic [31:0] mul_dataB;
   logic [63:0] mul_dataOut = '0;
   logic [31:0] rd_data;
   logic        busy;
   logic        done;
   logic        stall;

   int total = 0;
   int bad   = 0;

   mul_hilo_ctrl #(
      .MULTU (C_MULTU),
      .MFHI  (C_MFHI),
      .MFLO  (C_MFLO),
      .OUT   (C_OUT),
      .NOP   (C_NOP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .Signal      (Signal),
      .dataA       (dataA),
      .dataB       (dataB),
      .mul_signal  (mul_signal),
      .mul_dataA   (mul_dataA),
      .mul_dataB   (mul_dataB),
      .mul_dataOut (mul_dataOut),
      .rd_data     (rd_data),
      .busy        (busy),
      .done        (done),
      .stall       (stall)
   );

   always #5 clk = ~clk;

   // Behavioural multiplier: clears on the first MULTU cycle and presents
   // the full product only after it has seen the OUT code.
   logic [5:0] prev_sig = C_NOP;
   always @(posedge clk) begin
      if (mul_signal == C_MULTU && prev_sig != C_MULTU)
         mul_dataOut <= '0;
      else if (mul_signal == C_OUT)
         mul_dataOut <= {32'b0, mul_dataA} * {32'b0, mul_dataB};
      prev_sig <= mul_signal;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reads HI then LO through the combinational read port.
   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      Signal = C_MFHI; #1; hi = rd_data;
      Signal = C_MFLO; #1; lo = rd_data;
      Signal = C_NOP;  #1;
   endtask

   // Issues MULTU for one edge; on return edge 0 (accept) has happened.
   task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
      Signal = C_MULTU; dataA = a; dataB = b;
      tick();
      Signal = C_NOP;
   endtask

   // Watches from the current cycle (index start) until done; counts codes.
   task automatic watch_done(input int start, output int done_at,
                             output int n_multu, output int n_out, output int n_done);
      int cyc;
      cyc = start; done_at = -1; n_multu = 0; n_out = 0; n_done = 0;
      while (cyc < start + 60) begin
         if (mul_signal == C_MULTU) n_multu++;
         if (mul_signal == C_OUT)   n_out++;
         if (done) begin
            n_done++;
            if (done_at < 0) done_at = cyc;
         end
         if (done_at >= 0 && cyc > done_at + 1) break;
         tick();
         cyc++;
      end
   endtask

   initial begin
      logic [31:0] hi, lo;
      int d_at, nm, no, nd;

      #12;
      chk("rst_busy",  busy, 0);
      chk("rst_sig",   mul_signal, C_NOP);
      chk("rst_dA",    mul_dataA, 0);
      chk("rst_done",  done, 0);
      read_hilo(hi, lo);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      reset = 1'b1;
      #2;

      // 3 x 5: first MULTU after reset is accepted on the first edge
      start_mul(32'd3, 32'd5);
      chk("acc_busy", busy, 1);
      chk("acc_dA",   mul_dataA, 3);
      chk("acc_dB",   mul_dataB, 5);
      watch_done(0, d_at, nm, no, nd);
      chk("basic_done_at", d_at, 34);
      chk("basic_multu_n", nm, 32);
      chk("basic_out_n",   no, 1);
      chk("basic_done_w",  nd, 1);
      read_hilo(hi, lo);
      chk("basic_hi", hi, 0);
      chk("basic_lo", lo, 15);

      // maximum operands
      start_mul(32'hFFFFFFFF, 32'hFFFFFFFF);
      watch_done(0, d_at, nm, no, nd);
      read_hilo(hi, lo);
      chk("max_hi", hi, 32'hFFFFFFFE);
      chk("max_lo", lo, 32'h00000001);

      // set HI = 12345678, then read during the next multiply
      start_mul(32'h2468ACF0, 32'h80000000);
      watch_done(0, d_at, nm, no, nd);
      read_hilo(hi, lo);
      chk("pre_hi", hi, 32'h12345678);
      chk("pre_lo", lo, 0);
      start_mul(32'd3, 32'd5);
      for (int i = 0; i < 10; i++) tick();
      Signal = C_MFHI; #1;
      chk("busy_stall_hi", stall, 1);
      chk("busy_rd_hi",    rd_data, 32'h12345678);
      Signal = C_MFLO; #1;
      chk("busy_stall_lo", stall, 1);
      chk("busy_rd_lo",    rd_data, 0);
      Signal = C_NOP; #1;
      chk("nop_stall", stall, 0);
      chk("nop_rd",    rd_data, 0);
      watch_done(10, d_at, nm, no, nd);
      chk("rdb_done_at", d_at, 34);
      Signal = C_MFLO; #1;
      chk("after_stall", stall, 0);
      chk("after_lo",    rd_data, 15);
      Signal = C_NOP;

      // reset mid-run at count 10
      start_mul(32'd7, 32'd9);
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b0; #1;
      chk("rmid_busy", busy, 0);
      chk("rmid_sig",  mul_signal, C_NOP);
      read_hilo(hi, lo);
      chk("rmid_hi", hi, 0);
      chk("rmid_lo", lo, 0);
      tick();
      reset = 1'b1;
      watch_done(0, d_at, nm, no, nd);
      chk("rmid_no_done", nd, 0);
      chk("rmid_no_multu", nm, 0);

      // back-to-back: ignored while busy, accepted in the done cycle
      start_mul(32'd10, 32'd11);
      for (int i = 0; i < 5; i++) tick();
      Signal = C_MULTU; dataA = 32'd7; dataB = 32'd9;
      tick();
      Signal = C_NOP;
      chk("b2b_ign_dA", mul_dataA, 10);
      chk("b2b_ign_dB", mul_dataB, 11);
      chk("b2b_busy",   busy, 1);
      d_at = -1;
      for (int i = 0; i < 60 && d_at < 0; i++) begin
         if (done) d_at = i;
         else tick();
      end
      chk("b2b_first_done", (d_at >= 0), 1);
      read_hilo(hi, lo);
      chk("b2b_first_lo", lo, 110);
      start_mul(32'd7, 32'd9);
      chk("b2b_acc_busy", busy, 1);
      chk("b2b_acc_dA",   mul_dataA, 7);
      watch_done(0, d_at, nm, no, nd);
      chk("b2b_done_at", d_at, 34);
      read_hilo(hi, lo);
      chk("b2b_hi", hi, 0);
      chk("b2b_lo", lo, 63);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule : tb_mul_hilo_ctrl
